// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - state encodings and handshake constants for the radix-2 restoring divider
package div_unit_pkg;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - divider request/result bus; annul_i exists only with DIV_ANNUL_EN
interface div_unit_if #(
   parameter int WIDTH = 32
);
   logic                   start_i;
   logic                   signed_div_i;
   logic [WIDTH-1:0]       opdata1_i;
   logic [WIDTH-1:0]       opdata2_i;
`ifdef DIV_ANNUL_EN
   logic                   annul_i;
`endif
   logic [2*WIDTH-1:0]     result_o;
   logic                   ready_o;

   modport master (
      output start_i, signed_div_i, opdata1_i, opdata2_i,
`ifdef DIV_ANNUL_EN
      output annul_i,
`endif
      input  result_o, ready_o
   );

   modport slave (
      input  start_i, signed_div_i, opdata1_i, opdata2_i,
`ifdef DIV_ANNUL_EN
      input  annul_i,
`endif
      output result_o, ready_o
   );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring DIV/DIVU; optional in-flight abort via DIV_ANNUL_EN
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic      clk,
   input  logic      rst,
   div_unit_if.slave bus
);

   localparam int WW = 2 * WIDTH + 1;

   div_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WW-1:0]        work_q, work_d, work_step;
   logic [WIDTH-1:0]     divisor_q, divisor_d;
   logic                 quot_neg_q, quot_neg_d;
   logic                 rem_neg_q, rem_neg_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 ready_q, ready_d;

   logic [WIDTH:0]       diff;
   logic [WIDTH-1:0]     op1_abs, op2_abs, quot, rem;
   logic                 op1_neg, op2_neg, annul;

`ifdef DIV_ANNUL_EN
   assign annul = bus.annul_i;
`else
   assign annul = 1'b0;
`endif

   // Partial remainder lives in work[2W:W+1], quotient bits shift in at bit 0.
   always_comb begin
      op1_neg   = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
      op2_neg   = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
      op1_abs   = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
      op2_abs   = op2_neg ? -bus.opdata2_i : bus.opdata2_i;
      diff      = work_q[WW-1:WIDTH] - {1'b0, divisor_q};
      work_step = diff[WIDTH] ? {work_q[WW-2:0], 1'b0}
                              : {diff[WIDTH-1:0], work_q[WIDTH-1:0], 1'b1};
      quot      = quot_neg_q ? -work_step[WIDTH-1:0] : work_step[WIDTH-1:0];
      rem       = rem_neg_q ? -work_step[WW-1:WIDTH+1] : work_step[WW-1:WIDTH+1];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      work_d     = work_q;
      divisor_d  = divisor_q;
      quot_neg_d = quot_neg_q;
      rem_neg_d  = rem_neg_q;
      result_d   = result_q;
      ready_d    = ready_q;

      case (state_q)
         DIV_FREE: begin
            ready_d = DIV_RESULT_NOT_READY;
            if (bus.start_i == DIV_START) begin
               if (bus.opdata2_i == '0) begin
                  state_d = DIV_BYZERO;
               end else begin
                  state_d    = DIV_ON;
                  divisor_d  = op2_abs;
                  quot_neg_d = op1_neg ^ op2_neg;
                  rem_neg_d  = op1_neg;
                  cnt_d      = '0;
                  work_d     = {{WIDTH{1'b0}}, op1_abs, 1'b0};
               end
            end
         end
         DIV_BYZERO: begin
            state_d  = DIV_END;
            result_d = '0;
         end
         DIV_ON: begin
            work_d = work_step;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               result_d = {rem, quot};
               state_d  = DIV_END;
            end
         end
         default: begin
            if (bus.start_i == DIV_STOP) begin
               state_d  = DIV_FREE;
               ready_d  = DIV_RESULT_NOT_READY;
               result_d = '0;
            end else begin
               ready_d = DIV_RESULT_READY;
            end
         end
      endcase

      // A flushed divide must never reach HI/LO.
      if (annul && (state_q == DIV_ON || state_q == DIV_BYZERO)) begin
         state_d  = DIV_FREE;
         ready_d  = DIV_RESULT_NOT_READY;
         result_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= DIV_FREE;
         cnt_q      <= '0;
         work_q     <= '0;
         divisor_q  <= '0;
         quot_neg_q <= 1'b0;
         rem_neg_q  <= 1'b0;
         result_q   <= '0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         work_q     <= work_d;
         divisor_q  <= divisor_d;
         quot_neg_q <= quot_neg_d;
         rem_neg_q  <= rem_neg_d;
         result_q   <= result_d;
         ready_q    <= ready_d;
      end
   end

   assign bus.result_o = result_q;
   assign bus.ready_o  = ready_q;

endmodule
